// File: rtl/dmem_arbiter.sv
// Round-robin sequencer for the shared data-memory port: core (source 0) and DMA loader (source 1).
// Each access runs IDLE -> ACCESS -> DONE; the owner's ack is high for the single DONE cycle.
module dmem_arbiter #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  output logic          cpu_stall,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic [DW-1:0] dma_rdata,
  output logic          dma_ack,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_rd_en,
  output logic          mem_wr_en,
  input  logic [DW-1:0] mem_rdata,
  output logic          last_grant,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          last_grant_q, last_grant_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0] dma_rdata_q, dma_rdata_d;
  logic          cpu_ack_q, cpu_ack_d;
  logic          dma_ack_q, dma_ack_d;
  logic          grant_dma;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    last_grant_d = last_grant_q;
    cpu_rdata_d  = cpu_rdata_q;
    dma_rdata_d  = dma_rdata_q;
    cpu_ack_d    = 1'b0;
    dma_ack_d    = 1'b0;
    grant_dma    = 1'b0;
    case (state_q)
      IDLE: begin
        // On a tie the requester that did not win last time takes the port.
        grant_dma = dma_req & (~cpu_req | ~last_grant_q);
        if (cpu_req | dma_req) begin
          owner_d      = grant_dma;
          last_grant_d = grant_dma;
          we_d         = grant_dma ? dma_we    : cpu_we;
          addr_d       = grant_dma ? dma_addr  : cpu_addr;
          wdata_d      = grant_dma ? dma_wdata : cpu_wdata;
          state_d      = ACCESS;
        end
      end
      ACCESS: begin
        if (!we_q) begin
          if (owner_q) dma_rdata_d = mem_rdata;
          else         cpu_rdata_d = mem_rdata;
        end
        cpu_ack_d = ~owner_q;
        dma_ack_d = owner_q;
        state_d   = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!reset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      last_grant_q <= 1'b1;
      cpu_rdata_q  <= '0;
      dma_rdata_q  <= '0;
      cpu_ack_q    <= 1'b0;
      dma_ack_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      last_grant_q <= last_grant_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dma_rdata_q  <= dma_rdata_d;
      cpu_ack_q    <= cpu_ack_d;
      dma_ack_q    <= dma_ack_d;
    end
  end

  // Enables are gated by reset so a write caught mid-ACCESS can never commit.
  assign mem_wr_en  = reset & (state_q == ACCESS) &  we_q;
  assign mem_rd_en  = reset & (state_q == ACCESS) & ~we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign dma_rdata  = dma_rdata_q;
  assign cpu_ack    = cpu_ack_q;
  assign dma_ack    = dma_ack_q;
  assign cpu_stall  = cpu_req & ~cpu_ack_q;
  assign last_grant = last_grant_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural data_mem, transaction-level round-robin model,
// directed steps plus randomized traffic, immediate-assertion checks.
module tb_dmem_arbiter;

  logic       CLK = 1'b0;
  logic       reset;
  logic       cpu_req, cpu_we, dma_req, dma_we;
  logic [7:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic [7:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
  logic       cpu_ack, cpu_stall, dma_ack, mem_rd_en, mem_wr_en, last_grant;
  logic [1:0] dbg_state;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
  } txn_t;

  txn_t       cpu_pend[$];
  txn_t       dma_pend[$];
  logic [7:0] mem[256];
  logic [7:0] ref_mem[256];
  logic       m_last;
  logic [7:0] m_cpu_rdata, m_dma_rdata, m_last_addr;

  dmem_arbiter #(.AW(8), .DW(8)) dut (
    .CLK(CLK), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
    .mem_rdata(mem_rdata), .last_grant(last_grant), .dbg_state(dbg_state)
  );

  // Clock and the data_mem stand-in (asynchronous read, write on posedge).
  always #5 CLK = ~CLK;
  assign mem_rdata = mem[mem_addr];
  always @(posedge CLK) if (mem_wr_en) mem[mem_addr] <= mem_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present the head of each pending queue; while the port is busy (scr=1) the
  // address/data lines carry junk, which the arbiter must ignore.
  task automatic drive(input bit scr);
    cpu_req = (cpu_pend.size() > 0);
    dma_req = (dma_pend.size() > 0);
    if (cpu_req && !scr) {cpu_we, cpu_addr, cpu_wdata} = cpu_pend[0];
    else {cpu_we, cpu_addr, cpu_wdata} = 17'($urandom);
    if (dma_req && !scr) {dma_we, dma_addr, dma_wdata} = dma_pend[0];
    else {dma_we, dma_addr, dma_wdata} = 17'($urandom);
  endtask

  // Runs all queued transactions from an IDLE start and returns one cycle into IDLE.
  // With requests kept continuously pending, every transaction takes exactly three
  // cycles: enable in cycle k%3==1, ack in cycle k%3==2 (k = posedges since start).
  task automatic run_txns();
    int   k;
    int   budget;
    logic own;
    logic exp_stall;
    txn_t cur;
    k = 0;
    own = 1'b0;
    budget = 3 * (cpu_pend.size() + dma_pend.size()) + 6;
    drive(1'b0);
    while ((cpu_pend.size() > 0 || dma_pend.size() > 0) && k < budget) begin
      @(posedge CLK);
      k++;
      #1 drive(k % 3 != 0);
      @(negedge CLK);
      exp_stall = (cpu_pend.size() > 0) && !(k % 3 == 2 && own == 1'b0);
      chk("cpu_stall", cpu_stall, exp_stall);
      if (k % 3 == 1) begin
        if (cpu_pend.size() > 0 && dma_pend.size() > 0) own = ~m_last;
        else own = (dma_pend.size() > 0);
        m_last = own;
        cur = own ? dma_pend[0] : cpu_pend[0];
        m_last_addr = cur.addr;
        chk("grant_owner", last_grant, own);
        chk("access_addr", mem_addr, cur.addr);
        chk("access_wr_en", mem_wr_en, cur.we);
        chk("access_rd_en", mem_rd_en, !cur.we);
        if (cur.we) chk("access_wdata", mem_wdata, cur.wdata);
        chk("access_no_ack", {cpu_ack, dma_ack}, 2'b00);
      end else if (k % 3 == 2) begin
        cur = own ? dma_pend[0] : cpu_pend[0];
        if (cur.we) ref_mem[cur.addr] = cur.wdata;
        else if (own) m_dma_rdata = ref_mem[cur.addr];
        else m_cpu_rdata = ref_mem[cur.addr];
        chk("ack_ports", {cpu_ack, dma_ack}, {!own, own});
        chk("done_enables", {mem_rd_en, mem_wr_en}, 2'b00);
        chk("cpu_rdata", cpu_rdata, m_cpu_rdata);
        chk("dma_rdata", dma_rdata, m_dma_rdata);
        if (own) void'(dma_pend.pop_front());
        else void'(cpu_pend.pop_front());
      end else begin
        chk("idle_quiet", {cpu_ack, dma_ack, mem_rd_en, mem_wr_en}, 4'b0000);
      end
    end
    if (cpu_pend.size() > 0 || dma_pend.size() > 0) begin
      chk("txn_timeout", 32'(cpu_pend.size() + dma_pend.size()), 32'd0);
      cpu_pend.delete();
      dma_pend.delete();
    end
    @(posedge CLK);
    #1 drive(1'b0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 8'h00;
      ref_mem[i] = 8'h00;
    end
    reset = 1'b0;
    drive(1'b0);
    cpu_req = 1'b1;
    m_last = 1'b1;
    m_cpu_rdata = 8'h00;
    m_dma_rdata = 8'h00;
    m_last_addr = 8'h00;

    // Reset values, with cpu_stall following cpu_req.
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_acks", {cpu_ack, dma_ack}, 2'b00);
    chk("rst_enables", {mem_rd_en, mem_wr_en}, 2'b00);
    chk("rst_rdata", {cpu_rdata, dma_rdata}, 16'h0000);
    chk("rst_mem_bus", {mem_addr, mem_wdata}, 16'h0000);
    chk("rst_last_grant", last_grant, 1'b1);
    chk("rst_stall", cpu_stall, 1'b1);
    chk("rst_state", dbg_state, 2'd0);
    @(posedge CLK);
    #1 reset = 1'b1;
    drive(1'b0);

    // Core store 0xA5 @ 0x10 then load it back.
    cpu_pend.push_back('{we: 1'b1, addr: 8'h10, wdata: 8'hA5});
    cpu_pend.push_back('{we: 1'b0, addr: 8'h10, wdata: 8'h00});
    run_txns();
    chk("store_load_value", cpu_rdata, 8'hA5);

    // Reset asserted during the ACCESS cycle of a DMA store.
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 8'h05; dma_wdata = 8'hFF;
    @(posedge CLK);
    #1 reset = 1'b0;
    @(negedge CLK);
    chk("rst_access_wr_en", mem_wr_en, 1'b0);
    @(posedge CLK);
    #1 reset = 1'b1;
    dma_req = 1'b0;
    m_last = 1'b1; m_cpu_rdata = 8'h00; m_dma_rdata = 8'h00; m_last_addr = 8'h00;
    @(negedge CLK);
    chk("rst_access_mem", mem[5], ref_mem[5]);
    chk("rst_access_state", dbg_state, 2'd0);
    chk("rst_access_last", last_grant, 1'b1);
    chk("rst_access_ack", {cpu_ack, dma_ack}, 2'b00);
    chk("rst_access_rdata", cpu_rdata, 8'h00);
    @(posedge CLK);
    @(negedge CLK);
    chk("rst_access_no_ack", dma_ack, 1'b0);
    @(posedge CLK);
    #1 drive(1'b0);

    // Simultaneous first request: core wins, DMA store follows.
    cpu_pend.push_back('{we: 1'b0, addr: 8'h01, wdata: 8'h00});
    dma_pend.push_back('{we: 1'b1, addr: 8'h02, wdata: 8'h3C});
    run_txns();
    chk("simul_mem", mem[2], 8'h3C);
    chk("simul_last", last_grant, 1'b1);

    // Sustained contention: four loads per requester.
    for (int i = 0; i < 4; i++) begin
      cpu_pend.push_back('{we: 1'b0, addr: 8'h10 + 8'(i), wdata: 8'h00});
      dma_pend.push_back('{we: 1'b0, addr: 8'h02 + 8'(i), wdata: 8'h00});
    end
    run_txns();

    // Request held across the ack edge with a new address.
    cpu_pend.push_back('{we: 1'b1, addr: 8'h11, wdata: 8'h5A});
    cpu_pend.push_back('{we: 1'b0, addr: 8'h20, wdata: 8'h00});
    cpu_pend.push_back('{we: 1'b0, addr: 8'h11, wdata: 8'h00});
    run_txns();

    // Randomized mixed traffic over a small address window.
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < int'($urandom_range(1, 4)); i++)
        cpu_pend.push_back('{we: 1'($urandom), addr: 8'($urandom_range(8'h40, 8'h47)), wdata: 8'($urandom)});
      for (int i = 0; i < int'($urandom_range(0, 4)); i++)
        dma_pend.push_back('{we: 1'($urandom), addr: 8'($urandom_range(8'h40, 8'h47)), wdata: 8'($urandom)});
      run_txns();
    end

    // Idle bus for ten cycles.
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK);
      @(negedge CLK);
      chk("idle_signals", {cpu_ack, dma_ack, mem_rd_en, mem_wr_en}, 4'b0000);
      chk("idle_addr_hold", mem_addr, m_last_addr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Sequencer and arbiter for the single data-memory port. It lets the processor core's load/store path and a host/DMA loader share `data_mem`. Each access runs as a fixed three-state transaction, arbitrated round-robin between the two requesters. It also produces the stall that holds the program counter while a core access is outstanding. The block sits between the core datapath (address from source 0, write data from source 1) and `data_mem`.

## Interface
Parameters:
- `AW`, 8, address width
- `DW`, 8, data width

Ports:
- `CLK`  in  1  clock; all state updates on posedge
- `reset`  in  1  synchronous, active-low reset
- `cpu_req`  in  1  core request; level, held until `cpu_ack`
- `cpu_we`  in  1  1 = store, 0 = load
- `cpu_addr`  in  AW  core address
- `cpu_wdata`  in  DW  core store data
- `cpu_rdata`  out  DW  registered load data; valid while `cpu_ack`=1, held until next core load
- `cpu_ack`  out  1  one-cycle completion pulse
- `cpu_stall`  out  1  `cpu_req & ~cpu_ack`, combinational; PC hold
- `dma_req`, `dma_we`, `dma_addr`, `dma_wdata`, `dma_rdata`, `dma_ack`  same directions, widths and meaning for the loader port
- `mem_addr`  out  AW  to `data_mem`
- `mem_wdata`  out  DW  to `data_mem`
- `mem_rd_en`  out  1  read enable
- `mem_wr_en`  out  1  write enable; memory commits on the posedge ending a cycle with `mem_wr_en`=1
- `mem_rdata`  in  DW  asynchronous read data from `data_mem`
- `last_grant`  out  1  0 = core, 1 = DMA; owner of the most recent grant

## Operation
- States: IDLE, ACCESS, DONE. Registered fields: owner, `we`, `addr`, `wdata`.
- IDLE:
  - Neither request high: stay in IDLE.
  - Exactly one request high: grant it.
  - Both high: grant the requester that is not `last_grant`.
  - On a grant: latch owner, `we`, `addr` and `wdata`; update `last_grant`; next state ACCESS.
- ACCESS:
  - `mem_addr`/`mem_wdata` come from the latched fields.
  - `mem_wr_en` = latched `we`; `mem_rd_en` = ~latched `we`.
  - On a load, capture `mem_rdata` into the owner's rdata register at the posedge.
  - Next state DONE.
- DONE: assert the owner's ack for one cycle; enables are 0; next state IDLE.
- Requester rule:
  - A requester samples its ack at a posedge and on that same edge either drops its request or presents a new one.
  - A request still high in the following IDLE cycle is treated as a new transaction.
- Request inputs are ignored outside IDLE. Changes to a requester's address or data after its grant have no effect.
- The non-owner's rdata register and ack are untouched throughout.
- `mem_addr`/`mem_wdata` hold the last latched values in IDLE and DONE. Enables are 0 outside ACCESS.
- Reset (`reset`=0 at a posedge):
  - state = IDLE; `last_grant` = 1, so the core wins the first tie.
  - Latched fields, `cpu_rdata` and `dma_rdata` = 0; both acks = 0.
  - Any in-flight transaction is discarded with no ack.
- `mem_rd_en` and `mem_wr_en` are combinationally forced to 0 while `reset`=0. A write in ACCESS during reset therefore never commits.

## Timing
- Uncontended latency: request seen in IDLE at edge E0, ACCESS cycle, ack high in the cycle after E1, sampled at E2. That is 3 cycles per transaction, back-to-back rate 1 per 3 cycles.
- Fairness: with both requesters continuously active, grants strictly alternate.
- Any compliant request is acked within 6 cycles of first being seen high at a posedge.
- Load data reaches `x_rdata` at the ACCESS→DONE edge. It is stable during the ack cycle.
- Store data reaches memory at the ACCESS→DONE edge. A load issued in the next transaction returns the new value.
- `cpu_stall` is low in the ack cycle, so the PC advances on the same edge that retires the access.
- Reset values of all outputs:
  - `cpu_ack`, `dma_ack`, `mem_rd_en`, `mem_wr_en` = 0
  - `cpu_rdata`, `dma_rdata`, `mem_addr`, `mem_wdata` = 0
  - `last_grant` = 1
  - `cpu_stall` follows `cpu_req`

## Test plan
- **Core store then load:** after reset, core stores 0xA5 at 0x10, then loads 0x10. Required: `mem_wr_en` high for exactly 1 cycle with addr 0x10; first `cpu_ack` 2 cycles after the grant edge; load returns `cpu_rdata`=0xA5 with `cpu_ack`; `cpu_stall` high for exactly 2 cycles per access.
- **Simultaneous first request:** after reset, core loads 0x01 and DMA stores 0x3C at 0x02 in the same cycle. Required: core granted first (`last_grant`→0); DMA write lands 3 cycles later; `last_grant`=1 at the end.
- **Sustained contention:** both requesters issue 4 back-to-back loads each. Required: acks alternate core, DMA, core, DMA…; 8 acks in 24 cycles; no ack ever asserted on both ports together.
- **Request held after ack:** core keeps `cpu_req`=1 with a new address 0x20 on the ack edge. Required: a second transaction to 0x20 starts in the next IDLE; no duplicate access to the old address.
- **Reset during ACCESS:** DMA store of 0xFF to 0x05 (memory holds 0x00); `reset`=0 during the ACCESS cycle. Required: `mem_wr_en`=0 that cycle; memory[0x05] stays 0x00; no `dma_ack`; state IDLE; `last_grant`=1.
- **Idle bus:** no requests for 10 cycles. Required: enables stay 0; acks stay 0; `mem_addr` holds its last value.
